// File: rtl/extensor_pipe.sv
// Immediate extender with a 2-entry output FIFO and a count of output transfers.
// The extension is computed combinationally and registered into the FIFO, so latency is one cycle.
module extensor_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam int EXT_W = OUT_W - IN_W;

  logic [1:0]       occ_p1;
  logic             vld_p1;
  logic [OUT_W-1:0] ext_p0;
  logic [OUT_W-1:0] head_p1;
  logic [OUT_W-1:0] tail_p1;
  logic             push;
  logic             pop;

  function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] d, input logic [1:0] m);
    logic signed [OUT_W-1:0] sx;
    logic [OUT_W-1:0]        r;
    sx = {{EXT_W{d[IN_W-1]}}, d};
    case (m)
      2'b00:   r = {{EXT_W{1'b0}}, d};
      2'b01:   r = sx;
      2'b10:   r = sx <<< 2;
      default: r = {d, {EXT_W{1'b0}}};
    endcase
    return r;
  endfunction

  // Stage p0: combinational extension of the incoming immediate
  assign ext_p0 = extend(in_data, in_mode);

  assign in_ready  = (occ_p1 != 2'd2);
  assign vld_p1    = (occ_p1 != 2'd0);
  assign out_valid = vld_p1;
  assign push      = in_valid && in_ready;
  assign pop       = vld_p1 && out_ready;
  // Data registers are not reset; gating on valid keeps the output at zero when empty.
  assign out_data  = vld_p1 ? head_p1 : '0;

  // Stage p1: FIFO occupancy and transfer counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_p1   <= 2'd0;
      xfer_cnt <= '0;
    end else begin
      if (push && !pop)
        occ_p1 <= occ_p1 + 2'd1;
      else if (pop && !push)
        occ_p1 <= occ_p1 - 2'd1;
      if (pop)
        xfer_cnt <= xfer_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      if (occ_p1 == 2'd2)
        head_p1 <= tail_p1;
      else if (push)
        head_p1 <= ext_p0;
    end else if (push) begin
      if (occ_p1 == 2'd0)
        head_p1 <= ext_p0;
      else
        tail_p1 <= ext_p0;
    end
  end

endmodule

// File: tb/tb_extensor_pipe.sv
// Self-checking bench for extensor_pipe: directed cases plus randomized traffic
// compared against a queue-based reference model of the extension rules.
module tb_extensor_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] in_data = '0;
  logic [1:0]  in_mode = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  xfer_cnt;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] q[$];
  logic [7:0]  cnt_m = '0;

  extensor_pipe #(.IN_W(16), .OUT_W(32), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_mode  (in_mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .xfer_cnt (xfer_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [15:0] d, input logic [1:0] m);
    longint s;
    longint v;
    s = (d >= 16'h8000) ? longint'(d) - 65536 : longint'(d);
    case (m)
      2'd0:    v = longint'(d);
      2'd1:    v = s;
      2'd2:    v = s * 4;
      default: v = longint'(d) * 65536;
    endcase
    return v[31:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() > 0));
    chk({tag, ".out_data"},  64'(out_data),  64'((q.size() > 0) ? q[0] : 32'h0));
    chk({tag, ".in_ready"},  64'(in_ready),  64'(q.size() < 2));
    chk({tag, ".xfer_cnt"},  64'(xfer_cnt),  64'(cnt_m));
  endtask

  // One clock: apply inputs, advance the model by what must transfer, then compare.
  task automatic drive(input string tag, input bit iv, input logic [15:0] d,
                       input logic [1:0] m, input bit ordy);
    bit p_pop;
    bit p_push;
    in_valid  = iv;
    in_data   = d;
    in_mode   = m;
    out_ready = ordy;
    #1;
    p_pop  = (q.size() > 0) && ordy;
    p_push = iv && (q.size() < 2);
    if (p_pop) begin
      void'(q.pop_front());
      cnt_m++;
    end
    if (p_push) q.push_back(model(d, m));
    @(posedge clk);
    #1;
    chk_state(tag);
  endtask

  task automatic single(input logic [15:0] d, input logic [1:0] m, input logic [31:0] exp);
    drive("single_acc", 1'b1, d, m, 1'b1);
    chk("single_lit", 64'(out_data), 64'(exp));
    drive("single_drain", 1'b0, 16'h0, 2'd0, 1'b1);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.out_data",  64'(out_data),  64'd0);
    chk("rst.in_ready",  64'(in_ready),  64'd1);
    chk("rst.xfer_cnt",  64'(xfer_cnt),  64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Continuous streaming: 300 items, counter wraps past 255
    for (int i = 0; i < 300; i++)
      drive("stream", 1'b1, 16'(i), 2'(i % 4), 1'b1);
    drive("stream_tail", 1'b0, 16'h0, 2'd0, 1'b1);
    chk("stream.cnt44", 64'(xfer_cnt), 64'd44);

    // Directed extension values
    single(16'h8000, 2'd1, 32'hFFFF8000);
    single(16'h000F, 2'd1, 32'h0000000F);
    single(16'h8001, 2'd0, 32'h00008001);
    single(16'hFFFF, 2'd2, 32'hFFFFFFFC);
    single(16'h7FFF, 2'd2, 32'h0001FFFC);
    single(16'hE000, 2'd3, 32'hE0000000);

    // Back-pressure: two buffered, third held while stalled, then drained in order
    drive("bp_push1", 1'b1, 16'h0001, 2'd0, 1'b0);
    drive("bp_push2", 1'b1, 16'h0002, 2'd0, 1'b0);
    chk("bp.full_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      drive("bp_stall", 1'b1, 16'h0003, 2'd0, 1'b0);
      chk("bp.stable", 64'(out_data), 64'h1);
    end
    drive("bp_rel1", 1'b1, 16'h0003, 2'd0, 1'b1);
    chk("bp.second", 64'(out_data), 64'h2);
    drive("bp_rel2", 1'b1, 16'h0003, 2'd0, 1'b1);
    chk("bp.third", 64'(out_data), 64'h3);
    drive("bp_rel3", 1'b0, 16'h0000, 2'd0, 1'b1);
    chk("bp.empty", 64'(out_valid), 64'd0);

    // Randomized traffic across all modes
    for (int i = 0; i < 800; i++)
      drive("rand", 1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 3) != 0 || i % 50 < 10));

    // Reset with two items buffered
    drive("pre_rst_drain", 1'b0, 16'h0, 2'd0, 1'b1);
    drive("pre_rst_drain", 1'b0, 16'h0, 2'd0, 1'b1);
    drive("pre_rst_a", 1'b1, 16'hAAAA, 2'd1, 1'b0);
    drive("pre_rst_b", 1'b1, 16'h5555, 2'd0, 1'b0);
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst.out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst.xfer_cnt",  64'(xfer_cnt),  64'd0);
    chk("mid_rst.out_data",  64'(out_data),  64'd0);
    chk("mid_rst.in_ready",  64'(in_ready),  64'd1);
    q.delete();
    cnt_m = '0;
    @(posedge clk);
    #1;
    chk_state("rst_hold");
    @(negedge clk) rst_n = 1'b1;
    drive("post_rst_first", 1'b1, 16'h1234, 2'd1, 1'b1);
    chk("post_rst.lit", 64'(out_data), 64'h00001234);
    drive("post_rst_idle", 1'b0, 16'h0, 2'd0, 1'b1);
    for (int i = 0; i < 100; i++)
      drive("rand2", 1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
